// File: rtl/product_accumulator.sv
// Signed MAC accumulator: sums Term_Count 16-bit products, result valid one clock after the last strobe, held until Result_Ready.
// Backpressure: result holds in DONE until Result_Ready; ACC_SATURATE_EN selects clamping instead of wrapping on overflow.
module product_accumulator #(
  parameter int ACC_WIDTH   = 20,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Start,
  input  logic [COUNT_WIDTH-1:0] Term_Count,
  input  logic                   Abort,
  input  logic [15:0]            Product,
  input  logic                   Product_Valid,
  input  logic                   Result_Ready,
  output logic [ACC_WIDTH-1:0]   Acc_Out,
  output logic                   Acc_Valid,
  output logic                   Busy,
  output logic                   Overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;

  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]   sum;
  logic [ACC_WIDTH-1:0]   sat_val;
  logic                   add_ovf;
  logic                   take;

  assign prod_ext = {{(ACC_WIDTH-16){Product[15]}}, Product};
  assign sum      = acc_q + prod_ext;
  assign add_ovf  = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                    (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
  // Overflow can only happen with both addends sharing a sign, so acc sign picks the rail.
  assign sat_val  = acc_q[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  assign take     = (state_q == ST_ACCUM) && Product_Valid && !Abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = (Term_Count == '0) ? ST_DONE : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (Abort) state_d = ST_IDLE;
        else if (Product_Valid && rem_q == COUNT_WIDTH'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (Result_Ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    rem_d = rem_q;
    if (state_q == ST_IDLE && Start) begin
      acc_d = '0;
      ovf_d = 1'b0;
      rem_d = Term_Count;
    end else if (take) begin
      rem_d = rem_q - COUNT_WIDTH'(1);
      acc_d = sum;
      if (add_ovf) begin
        ovf_d = 1'b1;
`ifdef ACC_SATURATE_EN
        acc_d = sat_val;
`else
        acc_d = sum;
`endif
      end
    end
  end

`ifndef ACC_SATURATE_EN
  logic unused_sat;
  assign unused_sat = ^sat_val;
`endif

  always_comb begin
    Busy      = (state_q != ST_IDLE);
    Acc_Valid = (state_q == ST_DONE);
    Acc_Out   = acc_q;
    Overflow  = ovf_q;
  end

endmodule
